// File: rtl/pwm_carrier_gen.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | pwm_carrier_gen : prescaled up/down/up-down PWM carrier with min/max events,  |
// |                   masked shadow-update strobe and decimated interrupt.        |
// | Revision 1.0                                                                 |
// +-----------------------------------------------------------------------------+

package PKG_pwm;
    typedef enum logic {CARR_OFF = 1'b0, CARR_ON = 1'b1} carr_onoff_e;
    typedef enum logic {CLKDIV_OFF = 1'b0, CLKDIV_ON = 1'b1} clkdiv_onoff_e;
    typedef enum logic [1:0] {COUNT_UP = 2'd0, COUNT_DOWN = 2'd1, COUNT_UPDOWN = 2'd2} count_mode_e;
    typedef enum logic [1:0] {NO_MASK = 2'd0, MIN_MASK = 2'd1, MAX_MASK = 2'd2, MINMAX_MASK = 2'd3} mask_mode_e;
    typedef enum logic {INT_OFF = 1'b0, INT_ON = 1'b1} int_onoff_e;
endpackage

module pwm_carrier_gen
    import PKG_pwm::*;
#(
    parameter int PWMCOUNT_WIDTH = 16,
    parameter int DIVCLK_WIDTH   = 5,
    parameter int INTCOUNT_WIDTH = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      carr_onoff,
    input  logic                      clkdiv_onoff,
    input  logic [DIVCLK_WIDTH-1:0]   clkdiv,
    input  logic [1:0]                count_mode,
    input  logic [1:0]                mask_mode,
    input  logic [PWMCOUNT_WIDTH-1:0] period,
    input  logic [PWMCOUNT_WIDTH-1:0] init_val,
    input  logic                      int_onoff,
    input  logic [INTCOUNT_WIDTH-1:0] int_count,
    output logic [PWMCOUNT_WIDTH-1:0] carrier,
    output logic                      dir,
    output logic                      cnt_min,
    output logic                      cnt_max,
    output logic                      upd_strobe,
    output logic                      irq
);

    localparam logic [PWMCOUNT_WIDTH-1:0] C_CNT_ONE = PWMCOUNT_WIDTH'(1);
    localparam logic [DIVCLK_WIDTH-1:0]   C_PRE_ONE = DIVCLK_WIDTH'(1);
    localparam logic [INTCOUNT_WIDTH-1:0] C_INT_ONE = INTCOUNT_WIDTH'(1);

    logic                      r_run;
    logic [PWMCOUNT_WIDTH-1:0] r_ps;
    logic [1:0]                r_mode;
    logic [DIVCLK_WIDTH-1:0]   r_pre;
    logic [INTCOUNT_WIDTH-1:0] r_icnt;

    logic                      w_tick;
    logic                      w_step;
    logic [PWMCOUNT_WIDTH-1:0] w_nxt;
    logic                      w_dir_nxt;
    logic                      w_min;
    logic                      w_max;
    logic                      w_pass;
    logic                      w_irq_hit;
    logic [PWMCOUNT_WIDTH-1:0] w_init;
    logic [1:0]                w_mode_sel;

    always_comb begin
        w_tick    = (clkdiv_onoff != CLKDIV_ON) || (r_pre >= clkdiv);
        w_nxt     = carrier;
        w_dir_nxt = dir;
        case (r_mode)
            COUNT_DOWN:   w_nxt = (carrier == '0) ? r_ps : carrier - C_CNT_ONE;
            COUNT_UPDOWN: begin
                if ((!dir && carrier < r_ps) || (dir && carrier == '0))
                    w_nxt = carrier + C_CNT_ONE;
                else
                    w_nxt = carrier - C_CNT_ONE;
                // Direction follows the turning points; otherwise it tracks the step taken.
                if (w_nxt == r_ps)
                    w_dir_nxt = 1'b1;
                else if (w_nxt == '0)
                    w_dir_nxt = 1'b0;
                else
                    w_dir_nxt = (w_nxt < carrier);
            end
            default:      w_nxt = (carrier >= r_ps) ? '0 : carrier + C_CNT_ONE;
        endcase

        w_step    = r_run && w_tick && (r_ps != '0);
        w_min     = w_step && (w_nxt == '0);
        w_max     = w_step && (w_nxt == r_ps);
        w_pass    = (w_min && (mask_mode == NO_MASK || mask_mode == MAX_MASK)) ||
                    (w_max && (mask_mode == NO_MASK || mask_mode == MIN_MASK));
        w_irq_hit = (int_onoff == INT_ON) && w_pass && (r_icnt >= int_count);
        w_init    = (init_val > period) ? period : init_val;
        w_mode_sel = (count_mode == COUNT_DOWN || count_mode == COUNT_UPDOWN) ? count_mode : COUNT_UP;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_run      <= 1'b0;
            r_ps       <= '0;
            r_mode     <= '0;
            r_pre      <= '0;
            r_icnt     <= '0;
            carrier    <= '0;
            dir        <= 1'b0;
            cnt_min    <= 1'b0;
            cnt_max    <= 1'b0;
            upd_strobe <= 1'b0;
            irq        <= 1'b0;
        end else if (carr_onoff != CARR_ON) begin
            r_run      <= 1'b0;
            r_ps       <= period;
            r_mode     <= w_mode_sel;
            r_pre      <= '0;
            r_icnt     <= '0;
            carrier    <= w_init;
            dir        <= (count_mode == COUNT_DOWN);
            cnt_min    <= 1'b0;
            cnt_max    <= 1'b0;
            upd_strobe <= 1'b0;
            irq        <= 1'b0;
        end else begin
            // The first ON edge only arms the counter, giving the one-edge start latency.
            r_run      <= 1'b1;
            cnt_min    <= w_min;
            cnt_max    <= w_max;
            upd_strobe <= w_pass;
            irq        <= w_irq_hit;
            if (r_run) begin
                if (clkdiv_onoff == CLKDIV_ON)
                    r_pre <= w_tick ? '0 : r_pre + C_PRE_ONE;
                else
                    r_pre <= '0;
                if (w_tick) begin
                    carrier <= (r_ps == '0) ? '0 : w_nxt;
                    if (r_mode == COUNT_UPDOWN && r_ps != '0)
                        dir <= w_dir_nxt;
                end
                if (w_pass)
                    r_ps <= period;
                if (int_onoff != INT_ON)
                    r_icnt <= '0;
                else if (w_pass)
                    r_icnt <= w_irq_hit ? '0 : r_icnt + C_INT_ONE;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pwm_carrier_gen.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_pwm_carrier_gen : directed scoreboard bench for pwm_carrier_gen.          |
// | Revision 1.0                                                                 |
// +-----------------------------------------------------------------------------+
module tb_pwm_carrier_gen;
    import PKG_pwm::*;

    logic        clk;
    logic        rst;
    logic        carr_onoff;
    logic        clkdiv_onoff;
    logic [4:0]  clkdiv;
    logic [1:0]  count_mode;
    logic [1:0]  mask_mode;
    logic [15:0] period;
    logic [15:0] init_val;
    logic        int_onoff;
    logic [2:0]  int_count;
    logic [15:0] carrier;
    logic        dir;
    logic        cnt_min;
    logic        cnt_max;
    logic        upd_strobe;
    logic        irq;

    pwm_carrier_gen #(
        .PWMCOUNT_WIDTH (16),
        .DIVCLK_WIDTH   (5),
        .INTCOUNT_WIDTH (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .carr_onoff   (carr_onoff),
        .clkdiv_onoff (clkdiv_onoff),
        .clkdiv       (clkdiv),
        .count_mode   (count_mode),
        .mask_mode    (mask_mode),
        .period       (period),
        .init_val     (init_val),
        .int_onoff    (int_onoff),
        .int_count    (int_count),
        .carrier      (carrier),
        .dir          (dir),
        .cnt_min      (cnt_min),
        .cnt_max      (cnt_max),
        .upd_strobe   (upd_strobe),
        .irq          (irq)
    );

    // Flag field order: {dir, cnt_min, cnt_max, upd_strobe, irq}
    typedef struct packed {
        logic [15:0] car;
        logic [4:0]  flg;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    logic [20:0] act;
    int          checks = 0;
    int          errors = 0;
    int          vec_n  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: run did not complete, checks %0d", checks);
        $fatal(1, "watchdog expired");
    end

    always @(negedge clk) begin
        if (q.size() > 0) begin
            e   = q.pop_front();
            act = {carrier, dir, cnt_min, cnt_max, upd_strobe, irq};
            checks++;
            if (act !== {e.car, e.flg}) begin
                errors++;
                $display("FAIL vec%0d carrier/flags: got %0d/%b, expected %0d/%b",
                         vec_n, carrier, act[4:0], e.car, e.flg);
            end
            vec_n++;
        end
    end

    task automatic cyc(input logic [15:0] c, input logic [4:0] f);
        @(posedge clk);
        #1;
        q.push_back('{car: c, flg: f});
    endtask

    initial begin
        rst = 1'b1; carr_onoff = CARR_OFF; clkdiv_onoff = CLKDIV_OFF; clkdiv = 5'd0;
        count_mode = COUNT_UP; mask_mode = NO_MASK; period = 16'd3; init_val = 16'd0;
        int_onoff = INT_OFF; int_count = 3'd0;
        cyc(0, 5'b00000);
        rst = 1'b0;

        // UP, P=3, NO_MASK
        cyc(0, 5'b00000);
        carr_onoff = CARR_ON;
        cyc(0, 5'b00000);
        cyc(1, 5'b00000); cyc(2, 5'b00000); cyc(3, 5'b00110); cyc(0, 5'b01010);
        cyc(1, 5'b00000); cyc(2, 5'b00000); cyc(3, 5'b00110);

        // UPDOWN, P=4, MIN_MASK
        carr_onoff = CARR_OFF; count_mode = COUNT_UPDOWN; period = 16'd4; mask_mode = MIN_MASK;
        cyc(0, 5'b00000);
        carr_onoff = CARR_ON;
        cyc(0, 5'b00000);
        cyc(1, 5'b00000); cyc(2, 5'b00000); cyc(3, 5'b00000); cyc(4, 5'b10110);
        cyc(3, 5'b10000); cyc(2, 5'b10000); cyc(1, 5'b10000); cyc(0, 5'b01000);
        cyc(1, 5'b00000); cyc(2, 5'b00000); cyc(3, 5'b00000); cyc(4, 5'b10110);

        // Prescaler on, clkdiv=2, UP, P=2
        carr_onoff = CARR_OFF; count_mode = COUNT_UP; period = 16'd2; mask_mode = NO_MASK;
        clkdiv_onoff = CLKDIV_ON; clkdiv = 5'd2;
        cyc(0, 5'b00000);
        carr_onoff = CARR_ON;
        cyc(0, 5'b00000);
        cyc(0, 5'b00000); cyc(0, 5'b00000); cyc(1, 5'b00000);
        cyc(1, 5'b00000); cyc(1, 5'b00000); cyc(2, 5'b00110);
        cyc(2, 5'b00000); cyc(2, 5'b00000); cyc(0, 5'b01010);
        cyc(0, 5'b00000); cyc(0, 5'b00000); cyc(1, 5'b00000);

        // Interrupt decimation: irq on every third strobe, then INT_OFF
        carr_onoff = CARR_OFF; clkdiv_onoff = CLKDIV_OFF; period = 16'd3;
        int_onoff = INT_ON; int_count = 3'd2;
        cyc(0, 5'b00000);
        carr_onoff = CARR_ON;
        cyc(0, 5'b00000);
        cyc(1, 5'b00000); cyc(2, 5'b00000); cyc(3, 5'b00110); cyc(0, 5'b01010);
        cyc(1, 5'b00000); cyc(2, 5'b00000); cyc(3, 5'b00111); cyc(0, 5'b01010);
        cyc(1, 5'b00000); cyc(2, 5'b00000); cyc(3, 5'b00110); cyc(0, 5'b01011);
        int_onoff = INT_OFF;
        cyc(1, 5'b00000); cyc(2, 5'b00000); cyc(3, 5'b00110); cyc(0, 5'b01010);

        // DOWN, P=5, MAX_MASK; period changed to 2 while carrier=3
        carr_onoff = CARR_OFF; count_mode = COUNT_DOWN; period = 16'd5; init_val = 16'd5;
        mask_mode = MAX_MASK;
        cyc(5, 5'b10000);
        carr_onoff = CARR_ON;
        cyc(5, 5'b10000);
        cyc(4, 5'b10000); cyc(3, 5'b10000);
        period = 16'd2;
        cyc(2, 5'b10000); cyc(1, 5'b10000); cyc(0, 5'b11010);
        cyc(2, 5'b10100); cyc(1, 5'b10000); cyc(0, 5'b11010); cyc(2, 5'b10100);

        // MINMAX_MASK: period change never reaches the counter
        carr_onoff = CARR_OFF; period = 16'd5; mask_mode = MINMAX_MASK;
        cyc(5, 5'b10000);
        carr_onoff = CARR_ON;
        cyc(5, 5'b10000);
        cyc(4, 5'b10000);
        period = 16'd2;
        cyc(3, 5'b10000); cyc(2, 5'b10000); cyc(1, 5'b10000); cyc(0, 5'b11000);
        cyc(5, 5'b10100); cyc(4, 5'b10000);

        // Clamp: init_val=9, period=6
        carr_onoff = CARR_OFF; count_mode = COUNT_UP; init_val = 16'd9; period = 16'd6;
        mask_mode = NO_MASK;
        cyc(6, 5'b00000); cyc(6, 5'b00000);
        carr_onoff = CARR_ON;
        cyc(6, 5'b00000);
        cyc(0, 5'b01010); cyc(1, 5'b00000); cyc(2, 5'b00000);

        // Asynchronous reset mid-count: outputs clear before the next edge
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        q.push_back('{car: 16'd0, flg: 5'b00000});
        cyc(0, 5'b00000);
        rst = 1'b0;
        cyc(0, 5'b00000); cyc(0, 5'b00000); cyc(0, 5'b00000);
        carr_onoff = CARR_OFF;
        cyc(6, 5'b00000);

        @(posedge clk);
        @(posedge clk);
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, required 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pwm_carrier_gen.md
# pwm_carrier_gen

Carrier generator for the 8-carrier PWM subsystem. It produces one prescaled up, down or up/down counter and one-cycle min/max event pulses. It also produces a masked shadow-update strobe and an event-decimated interrupt pulse. It sits directly upstream of the per-channel compare/dead-time stages, which consume `carrier`, `upd_strobe` and `dir`. All mode inputs use the `PKG_pwm` enums.

## Interface
Parameters:
- `PWMCOUNT_WIDTH`, 16, carrier/period width
- `DIVCLK_WIDTH`, 5, prescaler ratio width
- `INTCOUNT_WIDTH`, 3, interrupt decimation width

Ports:
- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `carr_onoff`  in  1  `_carr_onoff`: CARR_ON runs the counter
- `clkdiv_onoff`  in  1  `_clkdiv_onoff`: enables the prescaler
- `clkdiv`  in  DIVCLK_WIDTH  tick every `clkdiv`+1 clk cycles when the prescaler is on
- `count_mode`  in  2  `_count_mode`: COUNT_UP / COUNT_DOWN / COUNT_UPDOWN (value 3 treated as COUNT_UP)
- `mask_mode`  in  2  `_mask_mode`: selects which events are suppressed from `upd_strobe`/`irq`
- `period`  in  PWMCOUNT_WIDTH  carrier maximum P (shadowed)
- `init_val`  in  PWMCOUNT_WIDTH  carrier start value while stopped
- `int_onoff`  in  1  `_int_onoff`: enables `irq`
- `int_count`  in  INTCOUNT_WIDTH  `irq` fires every `int_count`+1 unmasked events
- `carrier`  out  PWMCOUNT_WIDTH  counter value
- `dir`  out  1  0 = counting up, 1 = counting down
- `cnt_min`  out  1  one-cycle pulse: `carrier` became 0
- `cnt_max`  out  1  one-cycle pulse: `carrier` became P
- `upd_strobe`  out  1  one-cycle pulse: unmasked event, shadow-load point for downstream
- `irq`  out  1  one-cycle interrupt pulse

## Operation
- **Reset:** all outputs are 0. Shadow period `Ps`, latched mode, prescaler and interrupt counter are all 0.
- **Stopped (CARR_OFF):**
  - `carrier` = min(`init_val`, `period`).
  - `Ps` = `period` and the mode is latched from `count_mode` every cycle.
  - `dir` = 1 for DOWN, otherwise 0.
  - Prescaler and interrupt counter are held at 0.
  - No pulses are emitted.
- **Mode locking:** `count_mode` is ignored while running. A mode change requires OFF then ON.
- **Tick generation:**
  - Prescaler off: tick = 1 every cycle.
  - Prescaler on: `pre` increments each cycle. When `pre` >= `clkdiv`, tick = 1 and `pre` clears.
  - Lowering `clkdiv` below `pre` therefore ticks on the next cycle.
- **Counting, applied on each tick while running:**
  - UP: 0,1,…,Ps,0,…; period is Ps+1 ticks.
  - DOWN: Ps,…,0,Ps,…
  - UPDOWN: 0↑Ps↓0; period is 2·Ps ticks. `dir` flips in the same edge that `carrier` reaches Ps (to 1) or 0 (to 0).
  - Ps = 0: `carrier` holds 0 and no events are generated.
- **Events:**
  - `cnt_min` / `cnt_max` are asserted in the same cycle `carrier` is registered as 0 / Ps by a tick. They are never asserted by entering the stopped state.
  - In UP/DOWN, min and max fall on consecutive ticks.
- **Masking:**
  - NO_MASK: both events pass.
  - MIN_MASK: only max passes.
  - MAX_MASK: only min passes.
  - MINMAX_MASK: neither passes.
  - `mask_mode` is live (not shadowed).
- **Shadow update:** on the same edge that asserts `upd_strobe`, `Ps` ← `period`. The new period governs counting from the following tick. With MINMAX_MASK, `Ps` never updates while running.
- **Interrupt:**
  - With INT_ON, each `upd_strobe` increments `icnt`.
  - When `icnt` == `int_count`, `irq` pulses coincident with that `upd_strobe` and `icnt` ← 0.
  - INT_OFF: `icnt` is held at 0 and `irq` = 0.
  - Changing `int_count` below `icnt` fires on the next event.
- **Stop while running:** on the next edge the block enters the stopped state. Any in-flight pulse still lasts only its one cycle.
- **Width rules:** the counter never exceeds Ps, so there is no overflow. `init_val` is clamped to `period`.

## Timing
- All outputs are registered with no combinational input-to-output paths.
- **Start latency:** if CARR_ON is first sampled at edge k, the first carrier change happens at edge k+1 (prescaler off) or edge k+`clkdiv`+1 (prescaler on).
- **Pulses:** each pulse is high for exactly one clk cycle, regardless of prescaler.
- **Reset:** `rst` asserted at any time clears state immediately (asynchronously). After release, the first run requires CARR_ON to be sampled.

## Test plan
- **UP count:** UP, P=3, prescaler off, NO_MASK.
  - `carrier` = 0,1,2,3,0,1…
  - `cnt_max` pulses with 3 and `cnt_min` pulses with 0.
  - `upd_strobe` pulses on both; `dir` = 0 throughout.
- **UPDOWN count:** UPDOWN, P=4, MIN_MASK.
  - `carrier` = 0,1,2,3,4,3,2,1,0,1… with an 8-tick period.
  - `dir` goes to 1 at 4 and back to 0 at 0.
  - `upd_strobe` pulses only at 4.
- **Prescaler:** prescaler on, `clkdiv`=2, UP, P=2.
  - `carrier` advances exactly every 3 clk cycles.
  - First advance is 3 edges after CARR_ON is sampled; pulses stay one cycle wide.
- **Interrupt decimation:** UP, P=3, NO_MASK, INT_ON, `int_count`=2 → `irq` on every 3rd `upd_strobe`. Switching to INT_OFF → no `irq`.
- **Shadowed period:** DOWN, P=5, MAX_MASK; change `period` to 2 while `carrier`=3.
  - Sequence 3,2,1,0 (`Ps` loads here), then 2,1,0,2…
  - With MINMAX_MASK, the change never applies while running.
- **Stop, clamp and reset:**
  - `init_val`=9, `period`=6, CARR_OFF → `carrier`=6 with no pulses.
  - Assert `rst` mid-count → all outputs 0 immediately.
